uart_tx_fifo: RTL and testbench

Parameterised, buffered UART transmitter. It serialises bytes from a small internal FIFO onto `tx_o` as 8N1-style frames, using the same `CLK_CYCLES`/`BAUD_RATE`/`DATA_WIDTH` parameter set as `uart_rx`. It is the sending end of the link whose receiving end is `uart_rx`, and it sits between a byte producer (valid/ready) and the serial pin.

---
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of DATA_WIDTH-bit entries feeding an 8N1-style serialiser.
// Optional even-parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_CYCLES = 100_000_000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [DATA_WIDTH-1:0]         tx_byte_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          is_transmitting_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int BAUD_DIV = CLK_CYCLES / BAUD_RATE;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int IDX_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    baud_wrap;
  logic                    push, pop;
  logic [DATA_WIDTH-1:0]   head;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  assign tx_ready_o        = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifo_count_o      = count_q;
  assign tx_o              = tx_q;
  assign is_transmitting_o = (state_q != S_IDLE);
  assign push              = tx_valid_i && tx_ready_o;
  assign head              = mem[rd_ptr_q];
  assign baud_wrap         = (baud_q == BAUD_W'(BAUD_DIV - 1));

  // Storage is not reset; the cleared pointers and count make stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= tx_byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          idx_d   = '0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_wrap) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_wrap) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d = '0;
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = head;
              tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
              par_d   = ^head;
`endif
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single-byte frames plus reset, FIFO-full,
// back-to-back, simultaneous push/pop and two-stop-bit sequences (BAUD_DIV = 10).
module tb_uart_tx_fifo;

  localparam int D = 10;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (1 + 8 + P + 1) * D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte1, byte2;
  logic       valid1, valid2;
  logic       ready1, ready2, tx1, tx2, istx1, istx2;
  logic [2:0] cnt1, cnt2;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_CYCLES(1000), .BAUD_RATE(100), .DATA_WIDTH(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_byte_i(byte1), .tx_valid_i(valid1), .tx_ready_o(ready1),
    .tx_o(tx1), .is_transmitting_o(istx1), .fifo_count_o(cnt1));

  uart_tx_fifo #(.CLK_CYCLES(1000), .BAUD_RATE(100), .DATA_WIDTH(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .tx_byte_i(byte2), .tx_valid_i(valid2), .tx_ready_o(ready2),
    .tx_o(tx2), .is_transmitting_o(istx2), .fifo_count_o(cnt2));

  // seq lists the data bits in transmission order (leftmost first), worked out by hand.
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at the first cycle of a start bit; returns at the last stop-bit cycle.
  task automatic check_frame(input bit which, input logic [7:0] seq, input logic par,
                             input int nstop, input string tag);
    int nb;
    logic e;
    logic line;
    int bad;
    nb = 1 + 8 + P + nstop;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)              e = 1'b0;
      else if (b <= 8)         e = seq[8-b];
      else if (P == 1 && b == 9) e = par;
      else                     e = 1'b1;
      bad = 0;
      for (int c = 0; c < D; c++) begin
        if (b != 0 || c != 0) tick();
        line = which ? tx2 : tx1;
        if (line !== e) bad++;
      end
      check($sformatf("%s_bit%0d_bad_cycles", tag, b), bad, 0);
    end
  endtask

  task automatic wait_idle(input bit which);
    int n;
    n = 0;
    while (((which ? istx2 : istx1) || (which ? cnt2 : cnt1) != 0) && n < 5000) begin
      tick();
      n++;
    end
    check("idle_wait_in_budget", (n < 5000), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    logic rdy;

    tbl[0] = '{8'hA7, 8'b11100101, 1'b1};
    tbl[1] = '{8'h55, 8'b10101010, 1'b0};
    tbl[2] = '{8'h82, 8'b01000001, 1'b0};
    tbl[3] = '{8'h10, 8'b00001000, 1'b1};
    tbl[4] = '{8'h0F, 8'b11110000, 1'b0};
    tbl[5] = '{8'hFF, 8'b11111111, 1'b0};
    tbl[6] = '{8'h00, 8'b00000000, 1'b0};
    tbl[7] = '{8'h3C, 8'b00111100, 1'b0};

    rst_n = 1'b0; valid1 = 1'b0; valid2 = 1'b0; byte1 = '0; byte2 = '0;
    repeat (3) tick();
    check("rst_tx", tx1, 1);
    check("rst_ready", ready1, 1);
    check("rst_count", cnt1, 0);
    check("rst_istx", istx1, 0);
    #3 rst_n = 1'b1;
    tick();

    // Single-byte frames from the table.
    for (int i = 0; i < 8; i++) begin
      wait_idle(0);
      byte1 = tbl[i].data; valid1 = 1'b1;
      tick();
      valid1 = 1'b0;
      check($sformatf("v%0d_count_after_push", i), cnt1, 1);
      check($sformatf("v%0d_tx_idle_after_push", i), tx1, 1);
      check($sformatf("v%0d_istx_after_push", i), istx1, 0);
      tick();
      check($sformatf("v%0d_istx_rise", i), istx1, 1);
      check($sformatf("v%0d_count_popped", i), cnt1, 0);
      check_frame(0, tbl[i].seq, tbl[i].par, 1, $sformatf("v%0d", i));
      tick();
      check($sformatf("v%0d_istx_fall", i), istx1, 0);
      check($sformatf("v%0d_tx_idle", i), tx1, 1);
    end

    // Mid-frame reset: no frame after release.
    wait_idle(0);
    byte1 = 8'h55; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    repeat (46) tick();
    check("mid_pre_reset_istx", istx1, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx1, 1);
    check("mid_rst_count", cnt1, 0);
    check("mid_rst_istx", istx1, 0);
    check("mid_rst_ready", ready1, 1);
    @(posedge clk); #3 rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (tx1 !== 1'b1 || istx1 !== 1'b0 || cnt1 !== 3'd0) n++;
    end
    check("mid_no_frame_after_release", n, 0);

    // FIFO fill with valid held high, then five contiguous frames.
    wait_idle(0);
    fork
      begin
        k = 0; n = 0;
        byte1 = tbl[3].data; valid1 = 1'b1;
        while (k < 5 && n < 200) begin
          rdy = ready1;
          tick();
          n++;
          if (rdy) begin
            k++;
            if (k < 5) byte1 = tbl[3+k].data;
          end
        end
        valid1 = 1'b0;
        check("fill_edges", n, 5);
        check("peak_count", cnt1, 4);
        check("peak_ready", ready1, 0);
        n = 0;
        while (ready1 == 1'b0 && n < 500) begin
          tick();
          n++;
        end
        check("ready_rise_cycles", n, FRAME - 3);
        check("ready_rise_count", cnt1, 3);
      end
      begin
        int m;
        m = 0;
        do begin
          tick();
          m++;
        end while (tx1 !== 1'b0 && m < 20);
        check("b2b_first_start_edge", m, 2);
        for (int f = 0; f < 5; f++) begin
          check_frame(0, tbl[3+f].seq, tbl[3+f].par, 1, $sformatf("b2b%0d", f));
          tick();
          if (f < 4) check($sformatf("b2b%0d_istx_held", f), istx1, 1);
        end
        check("b2b_istx_fall", istx1, 0);
      end
    join

    // Push exactly at the STOP->START pop edge with two entries queued.
    wait_idle(0);
    byte1 = tbl[0].data; valid1 = 1'b1;
    tick();
    byte1 = tbl[1].data;
    tick();
    byte1 = tbl[2].data;
    tick();
    valid1 = 1'b0;
    check("simul_count_setup", cnt1, 2);
    repeat (FRAME - 2) @(posedge clk);
    #1;
    check("simul_count_pre", cnt1, 2);
    check("simul_last_stop", tx1, 1);
    byte1 = tbl[3].data; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    check("simul_count_held", cnt1, 2);
    for (int f = 0; f < 3; f++) begin
      check_frame(0, tbl[1+f].seq, tbl[1+f].par, 1, $sformatf("simul%0d", f));
      tick();
    end
    check("simul_istx_fall", istx1, 0);
    check("simul_count_end", cnt1, 0);

    // Two stop bits: 0x00 then 0xFF, stop period 2*D high before the next start.
    wait_idle(1);
    byte2 = tbl[6].data; valid2 = 1'b1;
    tick();
    byte2 = tbl[5].data;
    tick();
    valid2 = 1'b0;
    check("stop2_istx", istx2, 1);
    check_frame(1, tbl[6].seq, tbl[6].par, 2, "stop2_f0");
    tick();
    check_frame(1, tbl[5].seq, tbl[5].par, 2, "stop2_f1");
    tick();
    check("stop2_istx_fall", istx2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
